// File: rtl/ring_pkg.sv
// Shared definitions for the gold ring PE NIC: packet layout, routing
// constants and the minimal-direction route helper.
package ring_pkg;

   localparam int VC_BIT  = 63;
   localparam int DIR_BIT = 62;
   localparam int HOP_MSB = 55;
   localparam int HOP_LSB = 48;
   localparam int SRC_MSB = 47;
   localparam int SRC_LSB = 32;
   localparam int PAY_MSB = 31;
   localparam int PAY_LSB = 0;

   localparam logic       DIR_CW     = 1'b0;
   localparam logic       DIR_CCW    = 1'b1;
   localparam logic [7:0] HOP_1      = 8'h01;
   localparam logic [7:0] HOP_2      = 8'h03;
   localparam int         RING_NODES = 4;

   typedef struct packed {
      logic       dir;
      logic [7:0] hop;
      logic       self;   // destination is this node, nothing to send
   } route_t;

   typedef enum logic {TX_IDLE, TX_OFFER} tx_state_t;

   // d is the clockwise distance (dest - self) mod 4; the two-hop tie goes clockwise
   function automatic route_t route(input logic [1:0] d);
      route_t r;
      r.dir  = DIR_CW;
      r.hop  = HOP_1;
      r.self = 1'b0;
      case (d)
         2'd0: r.self = 1'b1;
         2'd1: r.hop  = HOP_1;
         2'd2: r.hop  = HOP_2;
         2'd3: r.dir  = DIR_CCW;
         default: r.self = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ring_sync_fifo.sv
// Synchronous FIFO with combinational head read. Pointers carry one extra
// bit so full and empty are distinguishable; push while full is accepted
// only together with a pop, and a pop while empty is ignored.
module ring_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // pointer update; storage itself needs no reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage write
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/ring_pe_nic.sv
// PE-side NIC for one gold ring node: routes core requests into 63-bit
// packets (vc added at injection from polarity), offers them on pesi/peri,
// and buffers ejected packets for the core.
module ring_pe_nic
   import ring_pkg::*;
#(
   parameter int NODE_ID  = 0,
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        polarity,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_dest,
   input  logic [31:0] req_payload,
   output logic        req_err,
   output logic        pesi,
   input  logic        peri,
   output logic [63:0] pedi,
   input  logic        peso,
   output logic        pero,
   input  logic [63:0] pedo,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [15:0] rx_source,
   output logic [31:0] rx_payload,
   output logic [15:0] tx_count,
   output logic [15:0] rx_count
);
   localparam int          TAW  = $clog2(TX_DEPTH);
   localparam int          RAW  = $clog2(RX_DEPTH);
   localparam logic [1:0]  SELF = 2'(NODE_ID);

   // ---------------- TX side ----------------
   route_t      rt;
   logic [62:0] tx_pkt, tx_head;
   logic        tx_push, tx_pop, tx_empty, tx_full, accept;
   logic [TAW:0] tx_occ;
   tx_state_t   state, state_nxt;
   logic        offer;

   assign rt        = route(req_dest - SELF);
   assign tx_pkt    = {rt.dir, 6'b0, rt.hop, 16'(NODE_ID), req_payload};
   assign req_ready = reset && !tx_full;
   assign accept    = req_valid && req_ready;
   assign tx_push   = accept && !rt.self;
   assign tx_pop    = pesi && peri;
   assign pesi      = reset && offer;
   assign pedi      = pesi ? {polarity, tx_head} : 64'd0;

   ring_sync_fifo #(.WIDTH(63), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(tx_push), .wr_data(tx_pkt),
      .pop(tx_pop), .rd_data(tx_head), .empty(tx_empty), .full(tx_full),
      .count(tx_occ)
   );

   // TX FSM state register
   always_ff @(posedge clk) begin
      if (!reset) state <= TX_IDLE;
      else        state <= state_nxt;
   end

   // TX FSM next state: stay offering while entries remain after a handshake
   always_comb begin
      state_nxt = state;
      offer     = 1'b0;
      case (state)
         TX_IDLE:  if (!tx_empty) state_nxt = TX_OFFER;
         TX_OFFER: begin
            offer = 1'b1;
            if (peri && tx_occ == (TAW+1)'(1) && !tx_push) state_nxt = TX_IDLE;
         end
         default:  state_nxt = TX_IDLE;
      endcase
   end

   // injection counter and self-destination error pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_count <= '0;
         req_err  <= 1'b0;
      end else begin
         if (tx_pop) tx_count <= tx_count + 16'd1;
         req_err <= accept && rt.self;
      end
   end

   // ---------------- RX side ----------------
   logic [47:0]  rx_head;
   logic         rx_push, rx_pop, rx_empty, rx_full, pero_q;
   logic [RAW:0] rx_occ, rx_occ_nxt;
   logic         unused_pedo;

   assign unused_pedo = ^pedo[63:48];
   assign pero        = reset && pero_q;
   assign rx_push     = peso && pero && !rx_full;
   assign rx_valid    = reset && !rx_empty;
   assign rx_pop      = rx_valid && rx_ready;
   assign rx_source   = rx_head[47:32];
   assign rx_payload  = rx_head[31:0];
   assign rx_occ_nxt  = rx_occ + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);

   ring_sync_fifo #(.WIDTH(48), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .wr_data(pedo[SRC_MSB:PAY_LSB]),
      .pop(rx_pop), .rd_data(rx_head), .empty(rx_empty), .full(rx_full),
      .count(rx_occ)
   );

   // pero registered from next occupancy so it never follows peso combinationally
   always_ff @(posedge clk) begin
      if (!reset) begin
         pero_q   <= 1'b0;
         rx_count <= '0;
      end else begin
         pero_q <= (rx_occ_nxt < (RAW+1)'(RX_DEPTH));
         if (rx_push) rx_count <= rx_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_ring_pe_nic.sv
// Bench for ring_pe_nic: one instance per ring node, scoreboards for the
// injected packets of every node and the received packets of node 0.
module tb_ring_pe_nic;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        polarity = 1'b0;
   logic        req_valid [4];
   logic        req_ready [4];
   logic [1:0]  req_dest [4];
   logic [31:0] req_payload [4];
   logic        req_err [4];
   logic        pesi [4];
   logic        peri [4];
   logic [63:0] pedi [4];
   logic        peso [4];
   logic        pero [4];
   logic [63:0] pedo [4];
   logic        rx_valid [4];
   logic        rx_ready [4];
   logic [15:0] rx_source [4];
   logic [31:0] rx_payload [4];
   logic [15:0] tx_count [4];
   logic [15:0] rx_count [4];

   logic [63:0] tx_q [4][$];
   logic [47:0] rx_q [$];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : node
      ring_pe_nic #(.NODE_ID(g), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
         .clk(clk), .reset(reset), .polarity(polarity),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_dest(req_dest[g]), .req_payload(req_payload[g]),
         .req_err(req_err[g]), .pesi(pesi[g]), .peri(peri[g]),
         .pedi(pedi[g]), .peso(peso[g]), .pero(pero[g]), .pedo(pedo[g]),
         .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
         .rx_source(rx_source[g]), .rx_payload(rx_payload[g]),
         .tx_count(tx_count[g]), .rx_count(rx_count[g])
      );
   end

   function automatic logic [63:0] model(input int src, input int dest,
                                          input logic [31:0] pay, input logic vc);
      int d;
      logic dir;
      logic [7:0] hop;
      d   = (dest - src + 4) % 4;
      dir = (d == 3);
      hop = (d == 2) ? 8'h03 : 8'h01;
      return {vc, dir, 6'b0, hop, 16'(src), pay};
   endfunction

   // scoreboard checks at negedge, just before the handshake edge
   always @(negedge clk) begin
      if (reset) begin
         for (int g = 0; g < 4; g++) begin
            if (pesi[g] && peri[g]) begin
               n_tests++;
               if (tx_q[g].size() == 0) begin
                  n_fail++;
                  $display("FAIL tx_unexpected node%0d: got %h exp none", g, pedi[g]);
               end else begin
                  logic [63:0] e;
                  e = tx_q[g].pop_front();
                  if (pedi[g] !== e) begin
                     n_fail++;
                     $display("FAIL tx_pkt node%0d: got %h exp %h", g, pedi[g], e);
                  end
               end
            end
         end
         if (rx_valid[0] && rx_ready[0]) begin
            n_tests++;
            if (rx_q.size() == 0) begin
               n_fail++;
               $display("FAIL rx_unexpected: got %h exp none", {rx_source[0], rx_payload[0]});
            end else begin
               logic [47:0] e;
               e = rx_q.pop_front();
               if ({rx_source[0], rx_payload[0]} !== e) begin
                  n_fail++;
                  $display("FAIL rx_pkt: got %h exp %h", {rx_source[0], rx_payload[0]}, e);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      // intentionally unused elsewhere; comparisons are inline in each test
   endtask

   // drive one request; waits (bounded) for req_ready, then accepts on the next edge
   task automatic send(input int n, input int dest, input logic [31:0] pay, input bit track);
      int w;
      req_dest[n]    = 2'(dest);
      req_payload[n] = pay;
      req_valid[n]   = 1'b1;
      w = 0;
      while (!req_ready[n] && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout node%0d: got req_ready=0 exp 1", n);
      end else if (track && dest != n) begin
         tx_q[n].push_back(model(n, dest, pay, polarity));
      end
      tick();
      req_valid[n] = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      for (int g = 0; g < 4; g++) begin
         n_tests++;
         if ({pesi[g], pedi[g], rx_valid[g], req_ready[g], pero[g], req_err[g]} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_outputs node%0d: got pesi=%b pedi=%h rxv=%b rdy=%b pero=%b err=%b exp all 0",
                     g, pesi[g], pedi[g], rx_valid[g], req_ready[g], pero[g], req_err[g]);
         end
         n_tests++;
         if ({tx_count[g], rx_count[g]} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters node%0d: got tx=%0d rx=%0d exp 0 0", g, tx_count[g], rx_count[g]);
         end
      end
      reset = 1'b1;
      tick();
      n_tests++;
      if (req_ready[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b exp 1", req_ready[1]);
      end
   endtask

   // single injection with latency and pesi width check
   task automatic test_inject(input int n, input int dest, input logic [31:0] pay,
                              input logic pol, input logic [63:0] exp_pkt);
      logic [15:0] c0;
      polarity = pol;
      peri[n]  = 1'b1;
      c0 = tx_count[n];
      send(n, dest, pay, 1'b1);
      n_tests++;
      if (pesi[n] !== 1'b0) begin
         n_fail++;
         $display("FAIL inject_early node%0d: got pesi=%b exp 0", n, pesi[n]);
      end
      tick();
      n_tests++;
      if (pesi[n] !== 1'b1 || pedi[n] !== exp_pkt) begin
         n_fail++;
         $display("FAIL inject_pkt node%0d: got pesi=%b pedi=%h exp 1 %h", n, pesi[n], pedi[n], exp_pkt);
      end
      tick();
      n_tests++;
      if (pesi[n] !== 1'b0 || tx_count[n] !== c0 + 16'd1) begin
         n_fail++;
         $display("FAIL inject_done node%0d: got pesi=%b tx_count=%0d exp 0 %0d", n, pesi[n], tx_count[n], c0 + 16'd1);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] head;
      int hi;
      bit acc;
      polarity = 1'b0;
      peri[3]  = 1'b0;
      for (int i = 1; i <= 4; i++) send(3, 0, 32'(i), 1'b1);
      req_dest[3] = 2'd0;
      req_payload[3] = 32'd5;
      req_valid[3] = 1'b1;
      head = model(3, 0, 32'd1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         n_tests++;
         if (req_ready[3] !== 1'b0 || pesi[3] !== 1'b1 || pedi[3][62:0] !== head[62:0]) begin
            n_fail++;
            $display("FAIL bp_hold cyc%0d: got rdy=%b pesi=%b pedi=%h exp 0 1 %h",
                     i, req_ready[3], pesi[3], pedi[3][62:0], head[62:0]);
         end
         tick();
      end
      peri[3] = 1'b1;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         acc = req_valid[3] && req_ready[3];
         if (acc) tx_q[3].push_back(model(3, 0, 32'd5, 1'b0));
         if (pesi[3]) hi++;
         tick();
         if (acc) req_valid[3] = 1'b0;
      end
      n_tests++;
      if (hi != 5 || tx_count[3] !== 16'd5) begin
         n_fail++;
         $display("FAIL bp_drain: got pesi_cycles=%0d tx_count=%0d exp 5 5", hi, tx_count[3]);
      end
   endtask

   task automatic test_self_dest();
      peri[0] = 1'b1;
      req_dest[0] = 2'd0;
      req_payload[0] = 32'hdead_beef;
      req_valid[0] = 1'b1;
      n_tests++;
      if (req_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL self_ready: got %b exp 1", req_ready[0]);
      end
      tick();
      req_valid[0] = 1'b0;
      n_tests++;
      if (req_err[0] !== 1'b1 || pesi[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL self_err: got err=%b pesi=%b exp 1 0", req_err[0], pesi[0]);
      end
      tick();
      n_tests++;
      if (req_err[0] !== 1'b0 || pesi[0] !== 1'b0 || tx_count[0] !== 16'd0) begin
         n_fail++;
         $display("FAIL self_after: got err=%b pesi=%b tx_count=%0d exp 0 0 0", req_err[0], pesi[0], tx_count[0]);
      end
   endtask

   task automatic test_rx();
      logic [63:0] p;
      int w;
      rx_ready[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         p = {$urandom(), $urandom()};
         n_tests++;
         if (pero[0] !== (i < 4)) begin
            n_fail++;
            $display("FAIL rx_pero pulse%0d: got %b exp %b", i, pero[0], (i < 4));
         end
         if (i < 4) rx_q.push_back(p[47:0]);
         peso[0] = 1'b1;
         pedo[0] = p;
         tick();
      end
      peso[0] = 1'b0;
      n_tests++;
      if (pero[0] !== 1'b0 || rx_count[0] !== 16'd4 || rx_valid[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rx_full: got pero=%b rx_count=%0d rxv=%b exp 0 4 1", pero[0], rx_count[0], rx_valid[0]);
      end
      rx_ready[0] = 1'b1;
      w = 0;
      while (rx_valid[0] && w < 20) begin
         tick();
         w++;
      end
      tick();
      n_tests++;
      if (rx_q.size() != 0 || rx_valid[0] !== 1'b0 || pero[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rx_drain: got left=%0d rxv=%b pero=%b exp 0 0 1", rx_q.size(), rx_valid[0], pero[0]);
      end
   endtask

   task automatic test_all_routes();
      polarity = 1'b1;
      for (int n = 0; n < 4; n++) peri[n] = 1'b1;
      for (int n = 0; n < 4; n++)
         for (int d = 0; d < 4; d++)
            if (d != n) send(n, d, $urandom(), 1'b1);
      repeat (4) tick();
      for (int n = 0; n < 4; n++) begin
         n_tests++;
         if (tx_q[n].size() != 0) begin
            n_fail++;
            $display("FAIL routes_left node%0d: got %0d exp 0", n, tx_q[n].size());
         end
      end
   endtask

   task automatic test_mid_reset();
      peri[1] = 1'b0;
      rx_ready[1] = 1'b0;
      peso[1] = 1'b1;
      pedo[1] = 64'h0000_0002_1234_5678;
      send(1, 2, 32'h11, 1'b0);
      peso[1] = 1'b0;
      send(1, 3, 32'h22, 1'b0);
      n_tests++;
      if (pesi[1] !== 1'b1 || rx_valid[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_setup: got pesi=%b rxv=%b exp 1 1", pesi[1], rx_valid[1]);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (pesi[1] !== 1'b0 || req_ready[1] !== 1'b0 || rx_valid[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_in_reset: got pesi=%b rdy=%b rxv=%b exp 0 0 0", pesi[1], req_ready[1], rx_valid[1]);
      end
      tick();
      n_tests++;
      if (tx_count[1] !== 16'd0 || rx_count[1] !== 16'd0 || tx_count[3] !== 16'd0 || pesi[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_counters: got tx1=%0d rx1=%0d tx3=%0d pesi=%b exp 0 0 0 0",
                  tx_count[1], rx_count[1], tx_count[3], pesi[1]);
      end
      reset = 1'b1;
      peri[1] = 1'b1;
      #1;
      n_tests++;
      if (req_ready[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_release_ready: got %b exp 1", req_ready[1]);
      end
      repeat (3) tick();
      n_tests++;
      if (pesi[1] !== 1'b0 || rx_valid[1] !== 1'b0 || tx_count[1] !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_discard: got pesi=%b rxv=%b tx_count=%0d exp 0 0 0", pesi[1], rx_valid[1], tx_count[1]);
      end
   endtask

   initial begin
      for (int g = 0; g < 4; g++) begin
         req_valid[g] = 1'b0;
         req_dest[g] = 2'd0;
         req_payload[g] = 32'd0;
         peri[g] = 1'b0;
         peso[g] = 1'b0;
         pedo[g] = 64'd0;
         rx_ready[g] = 1'b0;
      end
      test_reset();
      test_inject(1, 0, 32'd1, 1'b0, 64'h4001_0001_0000_0001);
      test_inject(2, 0, 32'd0, 1'b1, 64'h8003_0002_0000_0000);
      test_backpressure();
      test_self_dest();
      test_rx();
      test_all_routes();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
